cipher_regfile: RTL
===================

// Module: cipher_regfile
// PURPOSE
// - Parametrised register bank for the decryption datapath: holds the MUX/DEMUX select and NUM_CIPHERS key registers.
// - Keys are double-buffered: a write lands in a shadow copy, which becomes active on a commit applied only while the engine is idle.
// - Sits between the host register-access bus and the cipher engines/MUX blocks; adds error rules, status and a commit handshake.
// PARAMETERS
// - ADDR_WIDTH  8      register address width
// - REG_WIDTH   16     register/data width
// - NUM_CIPHERS 3      number of key registers (0=caesar, 1=scytale, 2=zigzag)
// - SEL_WIDTH   2      implemented select bits; upper bits read 0
// - KEY_BASE    8'h10  address of key 0
// - KEY_STRIDE  2      address step between key registers
// - KEY_RST     {16'h2,16'hFFFF,16'h0}  packed reset values, key i at [i*REG_WIDTH +: REG_WIDTH]
// PORTS
// - clk         in   1                      system clock, all logic on posedge
// - rst_n       in   1                      synchronous, active-low reset
// - addr        in   ADDR_WIDTH             register address
// - read        in   1                      read strobe, one access per cycle
// - write       in   1                      write strobe
// - wdata       in   REG_WIDTH              write data
// - engine_idle in   1                      engines idle; a commit may be applied this cycle
// - rdata       out  REG_WIDTH              read data, registered
// - done        out  1                      access-complete pulse
// - error       out  1                      access-error pulse, only together with done
// - select      out  REG_WIDTH              MUX/DEMUX select, zero-extended from SEL_WIDTH bits
// - keys        out  NUM_CIPHERS*REG_WIDTH  active keys, key i at [i*REG_WIDTH +: REG_WIDTH]
// - commit_done out  1                      one-cycle pulse when shadow keys are applied
// BEHAVIOUR
// - Reset (clk edge with rst_n=0): rdata=0, done=0, error=0, select=0, commit_done=0, pending=0, locked=0; shadow and active keys = KEY_RST.
// - Map: 0x00 SELECT RW | 0x02 CTRL WO (bit0 commit, bit1 lock; reads 0) | 0x04 STATUS RO (bit0 pending, bit1 locked) | KEY_BASE+i*KEY_STRIDE key i RW (reads return the shadow copy).
// - Latency: done/error/rdata are valid exactly 1 cycle after the strobe cycle; all three are single-cycle pulses.
// - rdata = 0 in any cycle not answering a valid read.
// - Error cases (done=1, error=1, no state change, rdata=0): unmapped address; read and write together; write to STATUS.
// - Idle cycles (no read, no write) never assert done or error, whatever addr holds.
// - SELECT write stores wdata[SEL_WIDTH-1:0] and takes effect on the select output the next cycle. Select is not shadowed.
// - Commit state: IDLE -> PENDING on a CTRL write with bit0=1; PENDING -> IDLE on the first cycle with engine_idle=1.
//   - On that IDLE transition: active keys <= shadow, commit_done pulses the next cycle.
//   - Earliest apply is the cycle after the CTRL write.
//   - A commit request while already PENDING is accepted (done=1, error=0) and has no further effect.
// - Key write in the same cycle as a commit apply: apply takes the pre-write shadow; the new value stays in shadow.
// - Reset while PENDING: pending cleared, active keys = KEY_RST, no commit_done.
// CONFIGURATION
// - CIPHER_REGFILE_LOCK_EN defined:
//   - CTRL bit1=1 sets sticky locked, cleared only by reset.
//   - While locked, every write gives done=1 and error=1 with no state change; reads still work.
// - CIPHER_REGFILE_LOCK_EN undefined: CTRL bit1 is ignored, STATUS bit1 reads 0, no lock logic is synthesised.
// STRUCTURE
// - Package cipher_regfile_pkg holds:
//   - address localparams (ADDR_SELECT, ADDR_CTRL, ADDR_STATUS);
//   - CTRL/STATUS bit indices;
//   - default key constants;
//   - select encodings (SEL_CAESAR=0, SEL_SCYTALE=1, SEL_ZIGZAG=2).
// - Sub-module regfile_key_slot holds one shadow+active key pair with write-enable and apply inputs. It is instantiated NUM_CIPHERS times in a generate loop, and address decode stays in the top level.
// TESTING
// - Reset then read 0x12 -> next cycle done=1, error=0, rdata=16'hFFFF; keys[31:16]=16'hFFFF.
// - Write 0x10=16'h0005, read 0x10 -> rdata=5; keys[15:0] stays 0 until commit; write CTRL=1 with engine_idle=1 -> keys[15:0]=5, commit_done pulses.
// - Commit with engine_idle=0 for 10 cycles -> STATUS reads 1, keys unchanged; raise engine_idle -> keys update, STATUS reads 0.
// - Write 0x00=16'hFFFF -> select=16'h0003; read 0x00 -> rdata=3.
// - Errors: access 0x06; read+write to 0x00; write 0x04 -> each gives done=1, error=1, rdata=0, no register changes.
// - LOCK_EN build: write CTRL=2, then write 0x14=7 -> error=1, read 0x14 returns 2; STATUS bit1=1; reset clears the lock.

Source files
------------

// File: rtl/cipher_regfile_pkg.sv
// cipher_regfile_pkg
// Shared constants for the decryption-datapath register bank: register map,
// CTRL/STATUS bit positions, default key reset values, select encodings and
// the commit state type.
package cipher_regfile_pkg;

  localparam logic [7:0] ADDR_SELECT  = 8'h00;
  localparam logic [7:0] ADDR_CTRL    = 8'h02;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] KEY_BASE_DEF = 8'h10;
  localparam int         KEY_STRIDE_DEF = 2;

  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int CTRL_LOCK_BIT      = 1;
  localparam int STATUS_PENDING_BIT = 0;
  localparam int STATUS_LOCKED_BIT  = 1;

  localparam logic [15:0] KEY_RST_CAESAR  = 16'h0000;
  localparam logic [15:0] KEY_RST_SCYTALE = 16'hFFFF;
  localparam logic [15:0] KEY_RST_ZIGZAG  = 16'h0002;
  localparam logic [47:0] KEY_RST_DEF = {KEY_RST_ZIGZAG, KEY_RST_SCYTALE, KEY_RST_CAESAR};

  typedef enum logic [1:0] {
    SEL_CAESAR  = 2'd0,
    SEL_SCYTALE = 2'd1,
    SEL_ZIGZAG  = 2'd2
  } sel_e;

  typedef enum logic {
    CS_IDLE    = 1'b0,
    CS_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/cipher_regfile_key_slot.sv
// regfile_key_slot
// One double-buffered key: host writes land in the shadow copy, and the
// apply strobe copies shadow into the active copy seen by the engine.
// A write and an apply in the same cycle move the old shadow to active and
// keep the new value in shadow.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_wr_en, i_wdata shadow write
//   i_apply          copy shadow -> active
//   o_shadow         shadow value (host readback)
//   o_active         active value (engine key)
module regfile_key_slot #(
  parameter int                   REG_WIDTH = 16,
  parameter logic [REG_WIDTH-1:0] RST_VAL   = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic [REG_WIDTH-1:0] i_wdata,
  input  logic                 i_apply,
  output logic [REG_WIDTH-1:0] o_shadow,
  output logic [REG_WIDTH-1:0] o_active
);

  logic [REG_WIDTH-1:0] r_shadow;
  logic [REG_WIDTH-1:0] r_active;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow <= RST_VAL;
      r_active <= RST_VAL;
    end else begin
      if (i_wr_en) r_shadow <= i_wdata;
      if (i_apply) r_active <= r_shadow;
    end
  end

  assign o_shadow = r_shadow;
  assign o_active = r_active;

endmodule

// File: rtl/cipher_regfile.sv
// cipher_regfile
// Register bank for the decryption datapath: MUX/DEMUX select plus
// NUM_CIPHERS double-buffered keys, with a commit handshake that applies
// shadow keys only while the engines are idle.
// Optional feature macro: CIPHER_REGFILE_LOCK_EN (sticky write lock via CTRL bit1).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   addr, read, write,
//   wdata               host register access
//   engine_idle         commit may be applied this cycle
//   rdata, done, error  registered access response (single-cycle pulses)
//   select              zero-extended MUX/DEMUX select
//   keys                active keys, key i at [i*REG_WIDTH +: REG_WIDTH]
//   commit_done         pulse after shadow keys were applied
//
// Commit FSM
//   state      | meaning
//   CS_IDLE    | no commit outstanding
//   CS_PENDING | commit requested, waiting for engine_idle to apply
module cipher_regfile
  import cipher_regfile_pkg::*;
#(
  parameter int                               ADDR_WIDTH  = 8,
  parameter int                               REG_WIDTH   = 16,
  parameter int                               NUM_CIPHERS = 3,
  parameter int                               SEL_WIDTH   = 2,
  parameter logic [ADDR_WIDTH-1:0]            KEY_BASE    = ADDR_WIDTH'(KEY_BASE_DEF),
  parameter int                               KEY_STRIDE  = KEY_STRIDE_DEF,
  parameter logic [NUM_CIPHERS*REG_WIDTH-1:0] KEY_RST     = KEY_RST_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic                             read,
  input  logic                             write,
  input  logic [REG_WIDTH-1:0]             wdata,
  input  logic                             engine_idle,
  output logic [REG_WIDTH-1:0]             rdata,
  output logic                             done,
  output logic                             error,
  output logic [REG_WIDTH-1:0]             select,
  output logic [NUM_CIPHERS*REG_WIDTH-1:0] keys,
  output logic                             commit_done
);

  logic [REG_WIDTH-1:0]   r_rdata;
  logic                   r_done;
  logic                   r_error;
  logic [SEL_WIDTH-1:0]   r_select;
  logic                   r_commit_done;
  commit_state_e          r_state;
  commit_state_e          w_state_next;

  logic                   w_hit_select;
  logic                   w_hit_ctrl;
  logic                   w_hit_status;
  logic [NUM_CIPHERS-1:0] w_key_hit;
  logic                   w_any_key;
  logic                   w_mapped;
  logic                   w_access;
  logic                   w_err;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_commit_req;
  logic                   w_pending;
  logic                   w_apply;
  logic                   w_locked;
  logic [REG_WIDTH-1:0]   w_status;
  logic [REG_WIDTH-1:0]   w_key_rdata;
  logic [REG_WIDTH-1:0]   w_rd_data;
  logic [REG_WIDTH-1:0]   w_shadow [NUM_CIPHERS];
  logic [REG_WIDTH-1:0]   w_active [NUM_CIPHERS];

  // ---------------- address decode ----------------
  assign w_hit_select = (addr == ADDR_WIDTH'(ADDR_SELECT));
  assign w_hit_ctrl   = (addr == ADDR_WIDTH'(ADDR_CTRL));
  assign w_hit_status = (addr == ADDR_WIDTH'(ADDR_STATUS));
  assign w_any_key    = |w_key_hit;
  assign w_mapped     = w_hit_select | w_hit_ctrl | w_hit_status | w_any_key;

  assign w_access = read | write;
  // Locked writes are rejected like any other illegal access.
  assign w_err    = (read & write) | ~w_mapped | (write & w_hit_status) | (write & w_locked);
  assign w_wr_ok  = write & ~w_err;
  assign w_rd_ok  = read & ~w_err;

  assign w_commit_req = w_wr_ok & w_hit_ctrl & wdata[CTRL_COMMIT_BIT];

  // ---------------- key slots ----------------
  genvar g;
  generate
    for (g = 0; g < NUM_CIPHERS; g++) begin : g_key
      localparam logic [ADDR_WIDTH-1:0] KEY_ADDR = ADDR_WIDTH'(KEY_BASE + g * KEY_STRIDE);

      assign w_key_hit[g] = (addr == KEY_ADDR);

      regfile_key_slot #(
        .REG_WIDTH (REG_WIDTH),
        .RST_VAL   (KEY_RST[g*REG_WIDTH +: REG_WIDTH])
      ) u_slot (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_wr_en  (w_wr_ok & w_key_hit[g]),
        .i_wdata  (wdata),
        .i_apply  (w_apply),
        .o_shadow (w_shadow[g]),
        .o_active (w_active[g])
      );

      assign keys[g*REG_WIDTH +: REG_WIDTH] = w_active[g];
    end
  endgenerate

  // ---------------- optional lock ----------------
`ifdef CIPHER_REGFILE_LOCK_EN
  logic r_locked;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
    end else if (w_wr_ok & w_hit_ctrl & wdata[CTRL_LOCK_BIT]) begin
      r_locked <= 1'b1;
    end
  end

  assign w_locked = r_locked;
`else
  assign w_locked = 1'b0;
`endif

  // ---------------- commit FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= CS_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CS_IDLE:    if (w_commit_req) w_state_next = CS_PENDING;
      // A repeated request while pending changes nothing.
      CS_PENDING: if (engine_idle)  w_state_next = CS_IDLE;
      default:    w_state_next = CS_IDLE;
    endcase
  end

  always_comb begin
    w_pending = (r_state == CS_PENDING);
    w_apply   = w_pending & engine_idle;
  end

  // ---------------- read data ----------------
  always_comb begin
    w_status = '0;
    w_status[STATUS_PENDING_BIT] = w_pending;
    w_status[STATUS_LOCKED_BIT]  = w_locked;
  end

  always_comb begin
    w_key_rdata = '0;
    for (int k = 0; k < NUM_CIPHERS; k++) begin
      if (w_key_hit[k]) w_key_rdata = w_shadow[k];
    end
  end

  // CTRL is write-only and falls through to the zero default.
  always_comb begin
    w_rd_data = '0;
    if (w_hit_select)      w_rd_data = select;
    else if (w_hit_status) w_rd_data = w_status;
    else if (w_any_key)    w_rd_data = w_key_rdata;
  end

  // ---------------- registered response / select ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata       <= '0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_select      <= '0;
      r_commit_done <= 1'b0;
    end else begin
      r_done        <= w_access;
      r_error       <= w_access & w_err;
      r_rdata       <= w_rd_ok ? w_rd_data : '0;
      r_commit_done <= w_apply;
      if (w_wr_ok & w_hit_select) r_select <= wdata[SEL_WIDTH-1:0];
    end
  end

  assign rdata       = r_rdata;
  assign done        = r_done;
  assign error       = r_error;
  assign select      = {{(REG_WIDTH-SEL_WIDTH){1'b0}}, r_select};
  assign commit_done = r_commit_done;

endmodule
